mux_nx1_seq: RTL and testbench
==============================

MUX_NX1_SEQ -- requirements
Module: mux_nx1_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, data width of each input and of y.
REQ-002 The module SHALL have parameter DEPTH, default 16, number of inputs (legal range 2..256, need not be a power of two).
REQ-003 The module SHALL have localparam SEL_W = $clog2(DEPTH), the select width.
REQ-004 The module SHALL have port clk  input  1  clock; all logic SHALL be clocked on its rising edge.
REQ-005 The module SHALL have port rst  input  1  reset; reset SHALL be synchronous and active-high.
REQ-006 The module SHALL have port i  input  DEPTH x WIDTH (unpacked array [DEPTH-1:0]), data inputs.
REQ-007 The module SHALL have port s  input  SEL_W  manual select.
REQ-008 The module SHALL have port mode  input  1  0 = manual select, 1 = auto-scan.
REQ-009 The module SHALL have port in_valid  input  1  request to capture one sample.
REQ-010 The module SHALL have port y_ready  input  1  downstream accepts y.
REQ-011 The module SHALL have port y  output  WIDTH  registered selected data.
REQ-012 The module SHALL have port y_valid  output  1  y holds an unconsumed sample.
REQ-013 The module SHALL have port y_sel  output  SEL_W  index that produced y.
REQ-014 The module SHALL have port sel_err  output  1  index of the held sample was >= DEPTH.

Function
REQ-015 The module SHALL define load = in_valid && (!y_valid || y_ready).
REQ-016 On load, the module SHALL register y = i[idx], y_sel = idx, y_valid = 1 and sel_err = 0 one cycle later (latency 1).
REQ-017 If idx >= DEPTH on load, the module SHALL register y = 0, y_sel = idx and sel_err = 1, and y_valid SHALL still be 1.
REQ-018 The module SHALL set idx = s when mode = 0 or scan is compiled out, and idx = scan_ptr when mode = 1.
REQ-019 When y_valid = 1 and y_ready = 0, the module SHALL hold y, y_sel, y_valid and sel_err stable, and in_valid SHALL be ignored (no sample loss, no overwrite).
REQ-020 When y_valid = 1, y_ready = 1 and in_valid = 0, the module SHALL clear y_valid next cycle while y, y_sel and sel_err keep their last values.
REQ-021 When y_ready = 1 and in_valid = 1 are asserted together while y_valid = 1, the module SHALL load back-to-back, giving full throughput of one sample per cycle.
REQ-022 The module SHALL sample the i array only on the load cycle, and input changes at any other time SHALL NOT affect y.

Reset
REQ-023 When rst = 1 at a rising clk edge, the module SHALL set y = 0, y_valid = 0, y_sel = 0, sel_err = 0, scan_ptr = 0 and mode_q = 0.
REQ-024 Reset SHALL take priority over load, and a sample pending or stalled at reset SHALL be discarded.
REQ-025 The module SHALL perform no load in the cycle rst is asserted, and loads SHALL resume on the first edge with rst = 0.

Configuration
REQ-026 The module SHALL use the macro MUX_NX1_SCAN_EN to compile the auto-scan feature in or out.
REQ-027 With MUX_NX1_SCAN_EN defined, the module SHALL keep a registered scan_ptr (SEL_W bits) and a registered mode_q.
REQ-028 With MUX_NX1_SCAN_EN defined, the module SHALL set scan_ptr = s on a cycle where mode = 1 and mode_q = 0, and the load in that same cycle SHALL use s and then set scan_ptr = s+1 (wrapped).
REQ-029 With MUX_NX1_SCAN_EN defined, on every other load in mode 1 the module SHALL advance scan_ptr by 1, wrapping DEPTH-1 -> 0; scan_ptr SHALL never reach an index >= DEPTH.
REQ-030 With MUX_NX1_SCAN_EN defined, the module SHALL hold scan_ptr on stall or idle, and scan_ptr SHALL keep its value when mode returns to 0.
REQ-031 Without MUX_NX1_SCAN_EN, the module SHALL ignore the mode port, keep the port list identical, and implement no scan_ptr or mode_q flops.

Verification (WIDTH=8; DEPTH=16 unless stated; i[k] = 8'h10+k)
REQ-032 The bench SHALL check reset: rst=1 for 2 cycles with in_valid=1 -> y=0, y_valid=0, y_sel=0 and sel_err=0 throughout.
REQ-033 The bench SHALL check manual mode: mode=0, s=5, in_valid=1, y_ready=1 -> next cycle y=8'h15, y_sel=5, y_valid=1; then s=15 -> y=8'h1F.
REQ-034 The bench SHALL check stall: load s=3, then y_ready=0 for 4 cycles with s=7 and in_valid=1 -> y stays 8'h13 and y_sel stays 3; y_ready=1 -> y=8'h17 one cycle later.
REQ-035 The bench SHALL check scan (macro on): s=14, mode 0->1, in_valid=1 and y_ready=1 for 4 cycles -> y_sel sequence 14,15,0,1 and y sequence 8'h1E,8'h1F,8'h10,8'h11.
REQ-036 The bench SHALL check range error: DEPTH=10, mode=0, s=12, load -> y=0, y_sel=12, sel_err=1, y_valid=1; then s=9 -> y=8'h19, sel_err=0.
REQ-037 The bench SHALL check reset mid-operation: scanning at scan_ptr=6 with y_valid=1 stalled, assert rst for 1 cycle -> all outputs 0, and the next scan entry starts at s.

Source files
------------

// File: rtl/mux_nx1_seq.sv
// mux_nx1_seq: registered N:1 mux with a valid/ready output stage.
// Define MUX_NX1_SCAN_EN to build in the auto-scan index generator.
module mux_nx1_seq #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         i [DEPTH-1:0],
   input  logic [$clog2(DEPTH)-1:0] s,
   input  logic                     mode,
   input  logic                     in_valid,
   input  logic                     y_ready,
   output logic [WIDTH-1:0]         y,
   output logic                     y_valid,
   output logic [$clog2(DEPTH)-1:0] y_sel,
   output logic                     sel_err
);

   localparam int SEL_W = $clog2(DEPTH);
   localparam logic [SEL_W:0] DEPTH_X =
      (SEL_W+1)'(DEPTH);

   logic             load;
   logic [SEL_W-1:0] idx;
   logic             idx_ok;
   logic [WIDTH-1:0] pick;

   assign load   = in_valid && (!y_valid || y_ready);
   assign idx_ok = {1'b0, idx} < DEPTH_X;

   // Compare-based mux never indexes past DEPTH-1
   always_comb begin
      pick = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (idx == SEL_W'(k)) begin
            pick = i[k];
         end
      end
   end

`ifdef MUX_NX1_SCAN_EN
   localparam logic [SEL_W:0] LAST_X =
      (SEL_W+1)'(DEPTH-1);

   logic [SEL_W-1:0] scan_ptr;
   logic [SEL_W-1:0] scan_nxt;
   logic             mode_q;
   logic             entry;
   logic             s_ok;

   function automatic logic [SEL_W-1:0] wrap_inc(
      input logic [SEL_W-1:0] p
   );
      if ({1'b0, p} >= LAST_X) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign entry = mode && !mode_q;
   assign s_ok  = {1'b0, s} < DEPTH_X;

   // Scan entry seeds from s; an illegal s seeds 0
   always_comb begin
      idx      = s;
      scan_nxt = scan_ptr;
      unique case (1'b1)
         entry: begin
            idx      = s;
            scan_nxt = load ? wrap_inc(s)
                     : (s_ok ? s : '0);
         end
         (mode && !entry): begin
            idx = scan_ptr;
            if (load) begin
               scan_nxt = wrap_inc(scan_ptr);
            end
         end
         default: begin
            idx      = s;
            scan_nxt = scan_ptr;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_ptr <= '0;
         mode_q   <= 1'b0;
      end else begin
         scan_ptr <= scan_nxt;
         mode_q   <= mode;
      end
   end
`else
   logic mode_unused;

   assign mode_unused = mode;
   assign idx         = s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         y       <= '0;
         y_valid <= 1'b0;
         y_sel   <= '0;
         sel_err <= 1'b0;
      end else if (load) begin
         y       <= idx_ok ? pick : '0;
         y_valid <= 1'b1;
         y_sel   <= idx;
         sel_err <= !idx_ok;
      end else if (y_ready) begin
         y_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_nx1_seq.sv
// tb_mux_nx1_seq: directed table, corner sequences and random
// stimulus on DEPTH=16 and DEPTH=10 instances against a model.
module tb_mux_nx1_seq;

`ifdef MUX_NX1_SCAN_EN
   localparam bit SCAN = 1'b1;
`else
   localparam bit SCAN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       mode;
   logic       iv;
   logic       rdy;
   logic [3:0] s;
   logic [7:0] d16 [15:0];
   logic [7:0] d10 [9:0];
   logic [7:0] y16, y10;
   logic       v16, v10;
   logic [3:0] sel16, sel10;
   logic       e16, e10;

   int n_chk  = 0;
   int n_fail = 0;

   mux_nx1_seq #(.WIDTH(8), .DEPTH(16)) u16 (
      .clk(clk), .rst(rst), .i(d16), .s(s),
      .mode(mode), .in_valid(iv), .y_ready(rdy),
      .y(y16), .y_valid(v16), .y_sel(sel16),
      .sel_err(e16)
   );

   mux_nx1_seq #(.WIDTH(8), .DEPTH(10)) u10 (
      .clk(clk), .rst(rst), .i(d10), .s(s),
      .mode(mode), .in_valid(iv), .y_ready(rdy),
      .y(y10), .y_valid(v10), .y_sel(sel10),
      .sel_err(e10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] y;
      logic       v;
      logic [3:0] sel;
      logic       e;
      logic [3:0] ptr;
      logic       mq;
   } mdl_t;

   mdl_t m16, m10;

   typedef struct packed {
      logic       r;
      logic       md;
      logic [3:0] si;
      logic       iv;
      logic       rdy;
      logic [7:0] y16;
      logic [7:0] y10;
      logic       v;
      logic [3:0] sel;
      logic       e16;
      logic       e10;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic mdl_t step(input mdl_t m, input int d);
      mdl_t n;
      int   idx, val, si, pi, np;
      bit   ld, ent;
      n  = m;
      if (rst) return '0;
      si  = int'(s);
      pi  = int'(m.ptr);
      np  = pi;
      ld  = iv && (!m.v || rdy);
      ent = SCAN && mode && !m.mq;
      idx = (SCAN && mode && !ent) ? pi : si;
      if (idx >= d) val = 0;
      else if (d == 16) val = int'(d16[idx]);
      else val = int'(d10[idx]);
      if (ld) begin
         n.v   = 1'b1;
         n.sel = idx[3:0];
         n.e   = (idx >= d);
         n.y   = val[7:0];
      end else if (m.v && rdy) begin
         n.v = 1'b0;
      end
      if (SCAN) begin
         if (ent) begin
            if (si >= d) np = 0;
            else np = ld ? (si + 1) % d : si;
         end else if (mode && ld) begin
            np = (pi + 1) % d;
         end
         n.ptr = np[3:0];
         n.mq  = mode;
      end
      return n;
   endfunction

   task automatic tick();
      mdl_t n16, n10;
      n16 = step(m16, 16);
      n10 = step(m10, 10);
      @(posedge clk);
      #1;
      m16 = n16;
      m10 = n10;
      chk("m_y16",   32'(y16),   32'(m16.y));
      chk("m_v16",   32'(v16),   32'(m16.v));
      chk("m_sel16", 32'(sel16), 32'(m16.sel));
      chk("m_err16", 32'(e16),   32'(m16.e));
      chk("m_y10",   32'(y10),   32'(m10.y));
      chk("m_v10",   32'(v10),   32'(m10.v));
      chk("m_sel10", 32'(sel10), 32'(m10.sel));
      chk("m_err10", 32'(e10),   32'(m10.e));
   endtask

   int exp_sel [4];
   int es;

   initial begin
      m16  = '0;
      m10  = '0;
      rst  = 1'b1;
      mode = 1'b0;
      iv   = 1'b1;
      rdy  = 1'b1;
      s    = 4'd5;
      for (int k = 0; k < 16; k++) d16[k] = 8'(16 + k);
      for (int k = 0; k < 10; k++) d10[k] = 8'(16 + k);

      tbl[0]  = '{1,0, 5,1,1,8'h00,8'h00,0, 0,0,0};
      tbl[1]  = '{1,0, 5,1,1,8'h00,8'h00,0, 0,0,0};
      tbl[2]  = '{0,0, 5,1,1,8'h15,8'h15,1, 5,0,0};
      tbl[3]  = '{0,0,15,1,1,8'h1F,8'h00,1,15,0,1};
      tbl[4]  = '{0,0, 3,1,1,8'h13,8'h13,1, 3,0,0};
      tbl[5]  = '{0,0, 7,1,0,8'h13,8'h13,1, 3,0,0};
      tbl[6]  = '{0,0, 7,1,0,8'h13,8'h13,1, 3,0,0};
      tbl[7]  = '{0,0, 7,1,0,8'h13,8'h13,1, 3,0,0};
      tbl[8]  = '{0,0, 7,1,0,8'h13,8'h13,1, 3,0,0};
      tbl[9]  = '{0,0, 7,1,1,8'h17,8'h17,1, 7,0,0};
      tbl[10] = '{0,0, 7,0,1,8'h17,8'h17,0, 7,0,0};
      tbl[11] = '{0,0, 7,0,0,8'h17,8'h17,0, 7,0,0};
      tbl[12] = '{0,0,12,1,0,8'h1C,8'h00,1,12,0,1};
      tbl[13] = '{0,0, 9,1,1,8'h19,8'h19,1, 9,0,0};

      for (int r = 0; r < 14; r++) begin
         rst  = tbl[r].r;
         mode = tbl[r].md;
         s    = tbl[r].si;
         iv   = tbl[r].iv;
         rdy  = tbl[r].rdy;
         tick();
         chk($sformatf("t%0d_y16", r), 32'(y16), 32'(tbl[r].y16));
         chk($sformatf("t%0d_y10", r), 32'(y10), 32'(tbl[r].y10));
         chk($sformatf("t%0d_v", r),   32'(v16), 32'(tbl[r].v));
         chk($sformatf("t%0d_sel", r), 32'(sel10), 32'(tbl[r].sel));
         chk($sformatf("t%0d_e16", r), 32'(e16), 32'(tbl[r].e16));
         chk($sformatf("t%0d_e10", r), 32'(e10), 32'(tbl[r].e10));
      end

      // scan entry from s=14 with wrap
      rst = 1'b1; tick();
      rst = 1'b0; mode = 1'b0; s = 4'd14; iv = 1'b0; rdy = 1'b1;
      tick();
      exp_sel = '{14, 15, 0, 1};
      mode = 1'b1; iv = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tick();
         es = SCAN ? exp_sel[j] : 14;
         chk($sformatf("scan%0d_sel", j), 32'(sel16), 32'(es));
         chk($sformatf("scan%0d_y", j), 32'(y16), 32'(16 + es));
      end

      // reset while stalled mid-scan
      mode = 1'b0; s = 4'd4; iv = 1'b0; tick();
      mode = 1'b1; iv = 1'b1; rdy = 1'b1;
      tick(); tick();
      rdy = 1'b0; tick();
      chk("stall_v", 32'(v16), 32'd1);
      chk("stall_sel", 32'(sel16), SCAN ? 32'd5 : 32'd4);
      rst = 1'b1; tick();
      chk("mrst_y", 32'(y16), 32'd0);
      chk("mrst_v", 32'(v16), 32'd0);
      chk("mrst_sel", 32'(sel16), 32'd0);
      chk("mrst_err", 32'(e16), 32'd0);
      rst = 1'b0; s = 4'd9; rdy = 1'b1; tick();
      chk("mrst_entry_sel", 32'(sel16), 32'd9);
      chk("mrst_entry_y", 32'(y16), 32'h19);

      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         s   = 4'($urandom_range(0, 15));
         iv  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         for (int k = 0; k < 16; k++) d16[k] = 8'($urandom);
         for (int k = 0; k < 10; k++) d10[k] = 8'($urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
